// File: rtl/decifra_aes_iterativa.sv
// Iterative AES-128 decryption: one inverse round per clock, with valid/ready on input and output.
// Round keys are captured at acceptance, so the upstream key expansion may move on immediately.
module decifra_aes_iterativa (
  input  logic          clock,
  input  logic          reset,
  input  logic          entrada_valida,
  output logic          entrada_pronta,
  input  logic [127:0]  bloco_cifrado,
  input  logic [127:0]  chaveInicial,
  input  logic [1279:0] chaveExpandida,
  output logic          saida_valida,
  input  logic          saida_pronta,
  output logic [127:0]  saida
);

  typedef enum logic [1:0] {OCIOSO, RODADA, CONCLUIDO} fsm_t;

  // FIPS-197 inverse S-box; the first listed byte sits at index 255, so lookups use ~byte.
  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*((c + r) % 4) + r) -: 8] = s[127 - 8*(4*c + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++)
      o[8*k +: 8] = INV_SBOX[~s[8*k +: 8]];
    return o;
  endfunction

  // Coefficients 09/0b/0d/0e built from the x2/x4/x8 xtime chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [3:0][7:0] a, m9, mb, md, me;
    logic [7:0] x2, x4, x8;
    logic [31:0] o;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31 - 8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    o = '0;
    for (int j = 0; j < 4; j++)
      o[31 - 8*j -: 8] = me[j] ^ mb[(j + 1) % 4] ^ md[(j + 2) % 4] ^ m9[(j + 3) % 4];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
    return o;
  endfunction

  fsm_t           fsm_q, fsm_d;
  logic [3:0]     r_q, r_d;
  logic [127:0]   estado_q, estado_d;
  logic [1407:0]  chaves_q, chaves_d;
  logic [127:0]   rk_atual;
  logic [127:0]   apos_chave;

  // Round key r lives at [1407-128r -: 128]; rk0 is the cipher key at the top.
  assign rk_atual   = chaves_q[11'd1407 - {r_q, 7'd0} -: 128];
  assign apos_chave = inv_sub_bytes(inv_shift_rows(estado_q)) ^ rk_atual;

  always_comb begin
    fsm_d    = fsm_q;
    r_d      = r_q;
    estado_d = estado_q;
    chaves_d = chaves_q;
    case (fsm_q)
      OCIOSO: begin
        if (entrada_valida) begin
          estado_d = bloco_cifrado ^ chaveExpandida[127:0];
          chaves_d = {chaveInicial, chaveExpandida};
          r_d      = 4'd9;
          fsm_d    = RODADA;
        end
      end
      RODADA: begin
        if (r_q != 4'd0) begin
          estado_d = inv_mix_columns(apos_chave);
          r_d      = r_q - 4'd1;
        end else begin
          estado_d = apos_chave;
          fsm_d    = CONCLUIDO;
        end
      end
      CONCLUIDO: begin
        if (saida_pronta) fsm_d = OCIOSO;
      end
      default: fsm_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q    <= OCIOSO;
      r_q      <= 4'd0;
      estado_q <= '0;
      chaves_q <= '0;
    end else begin
      fsm_q    <= fsm_d;
      r_q      <= r_d;
      estado_q <= estado_d;
      chaves_q <= chaves_d;
    end
  end

  assign entrada_pronta = (fsm_q == OCIOSO);
  assign saida_valida   = (fsm_q == CONCLUIDO);
  assign saida          = estado_q;

endmodule

// File: tb/tb_decifra_aes_iterativa.sv
// Bench for decifra_aes_iterativa: FIPS-197 vectors plus a forward-cipher software model
// whose S-box is derived from GF(2^8) inversion and the affine map.
`timescale 1ns/1ps
module tb_decifra_aes_iterativa;

  logic          clock = 1'b0;
  logic          reset;
  logic          entrada_valida;
  logic          entrada_pronta;
  logic [127:0]  bloco_cifrado;
  logic [127:0]  chaveInicial;
  logic [1279:0] chaveExpandida;
  logic          saida_valida;
  logic          saida_pronta;
  logic [127:0]  saida;

  int tests = 0;
  int fails = 0;
  int ciclo = 0;
  logic [7:0] sbox_m [256];

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  decifra_aes_iterativa dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_valida (entrada_valida),
    .entrada_pronta (entrada_pronta),
    .bloco_cifrado  (bloco_cifrado),
    .chaveInicial   (chaveInicial),
    .chaveExpandida (chaveExpandida),
    .saida_valida   (saida_valida),
    .saida_pronta   (saida_pronta),
    .saida          (saida)
  );

  always #5 clock = ~clock;
  always @(posedge clock) ciclo <= ciclo + 1;

  // ---------------- software model (forward cipher) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] key_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    logic [1407:0] ks;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[1407 - 32*i -: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] ks);
    logic [127:0] s, o;
    logic [7:0] a0, a1, a2, a3;
    s = pt ^ ks[1407 -: 128];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) s[8*k +: 8] = sbox_m[s[8*k +: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      s = o;
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127 - 32*c -: 8]; a1 = s[119 - 32*c -: 8];
          a2 = s[111 - 32*c -: 8]; a3 = s[103 - 32*c -: 8];
          o[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          o[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          o[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          o[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        s = o;
      end
      s = s ^ ks[1407 - 128*rnd -: 128];
    end
    return s;
  endfunction

  // ---------------- drive helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input logic [127:0] ct, input logic [127:0] key);
    logic [1407:0] ks;
    ks = key_expand(key);
    bloco_cifrado  = ct;
    chaveInicial   = ks[1407:1280];
    chaveExpandida = ks[1279:0];
  endtask

  task automatic wait_valid(output bit ok);
    for (int i = 0; i < 40 && !saida_valida; i++) tick();
    ok = saida_valida;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; entrada_valida = 1'b1; saida_pronta = 1'b0;
    apply(CT_C1, KEY_C1);
    tick(); tick();
    tests++; if (entrada_pronta !== 1'b1) begin fails++; $display("FAIL reset_pronta: got %b want 1", entrada_pronta); end
    tests++; if (saida_valida !== 1'b0) begin fails++; $display("FAIL reset_valida: got %b want 0", saida_valida); end
    tests++; if (saida !== 128'h0) begin fails++; $display("FAIL reset_saida: got %h want 0", saida); end
    reset = 1'b0; entrada_valida = 1'b0;
    tick();
    tests++; if (entrada_pronta !== 1'b1) begin fails++; $display("FAIL reset_wins: pronta got %b want 1", entrada_pronta); end
    tests++; if (saida_valida !== 1'b0) begin fails++; $display("FAIL reset_idle_valida: got %b want 0", saida_valida); end
  endtask

  task automatic test_fips_c1();
    bit early = 1'b0;
    saida_pronta = 1'b1;
    apply(CT_C1, KEY_C1);
    entrada_valida = 1'b1;
    tick();
    entrada_valida = 1'b0;
    tests++; if (entrada_pronta !== 1'b0) begin fails++; $display("FAIL c1_accept: pronta got %b want 0", entrada_pronta); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (saida_valida !== 1'b0) early = 1'b1;
    end
    tests++; if (early) begin fails++; $display("FAIL c1_latency_early: valida got 1 want 0 before edge T+10"); end
    tick();
    tests++; if (saida_valida !== 1'b1) begin fails++; $display("FAIL c1_latency: valida got %b want 1 after T+10", saida_valida); end
    tests++; if (saida !== PT_C1) begin fails++; $display("FAIL c1_saida: got %h want %h", saida, PT_C1); end
    tick();
    tests++; if (saida_valida !== 1'b0) begin fails++; $display("FAIL c1_one_cycle: valida got %b want 0", saida_valida); end
    tests++; if (entrada_pronta !== 1'b1) begin fails++; $display("FAIL c1_pronta_back: got %b want 1", entrada_pronta); end
    tests++; if (saida !== PT_C1) begin fails++; $display("FAIL c1_hold_after: got %h want %h", saida, PT_C1); end
  endtask

  task automatic test_fips_b();
    bit ok;
    saida_pronta = 1'b1;
    apply(CT_B, KEY_B);
    entrada_valida = 1'b1;
    tick();
    entrada_valida = 1'b0;
    wait_valid(ok);
    tests++; if (!ok) begin fails++; $display("FAIL b_timeout: valida got 0 want 1"); end
    tests++; if (saida !== PT_B) begin fails++; $display("FAIL b_saida: got %h want %h", saida, PT_B); end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    bit bad = 1'b0;
    logic [127:0] bad_val = '0;
    saida_pronta = 1'b0;
    apply(CT_C1, KEY_C1);
    entrada_valida = 1'b1;
    tick();
    entrada_valida = 1'b0;
    apply(~CT_C1, KEY_B);
    wait_valid(ok);
    tests++; if (!ok) begin fails++; $display("FAIL bp_timeout: valida got 0 want 1"); end
    for (int i = 0; i < 6; i++) begin
      if (saida !== PT_C1 || saida_valida !== 1'b1 || entrada_pronta !== 1'b0) begin
        bad = 1'b1; bad_val = saida;
      end
      if (i == 5) saida_pronta = 1'b1;
      tick();
    end
    tests++; if (bad) begin fails++; $display("FAIL bp_hold: saida got %h want %h with valida=1 pronta=0", bad_val, PT_C1); end
    tests++; if (entrada_pronta !== 1'b1 || saida_valida !== 1'b0) begin
      fails++; $display("FAIL bp_release: pronta/valida got %b/%b want 1/0", entrada_pronta, saida_valida); end
  endtask

  task automatic test_back_to_back();
    int acc_t [2];
    logic [127:0] outs [2];
    int nacc = 0;
    int nout = 0;
    bit vai;
    acc_t[0] = 0; acc_t[1] = 0; outs[0] = '0; outs[1] = '0;
    saida_pronta = 1'b1;
    apply(CT_B, KEY_B);
    entrada_valida = 1'b1;
    for (int i = 0; i < 60 && nout < 2; i++) begin
      vai = entrada_pronta && entrada_valida;
      if (saida_valida && saida_pronta) begin
        if (nout < 2) outs[nout] = saida;
        nout++;
      end
      tick();
      if (vai) begin
        if (nacc < 2) acc_t[nacc] = ciclo;
        nacc++;
        if (nacc == 1) apply(CT_C1, KEY_C1);
        else entrada_valida = 1'b0;
      end
    end
    entrada_valida = 1'b0;
    tests++; if (nacc != 2) begin fails++; $display("FAIL b2b_accepts: got %0d want 2", nacc); end
    tests++; if (acc_t[1] - acc_t[0] != 12) begin fails++; $display("FAIL b2b_spacing: got %0d want 12", acc_t[1] - acc_t[0]); end
    tests++; if (outs[0] !== PT_B) begin fails++; $display("FAIL b2b_out0: got %h want %h", outs[0], PT_B); end
    tests++; if (outs[1] !== PT_C1) begin fails++; $display("FAIL b2b_out1: got %h want %h", outs[1], PT_C1); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit stale = 1'b0;
    saida_pronta = 1'b1;
    apply(CT_C1, KEY_C1);
    entrada_valida = 1'b1;
    tick();
    entrada_valida = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (saida_valida !== 1'b0) begin fails++; $display("FAIL mid_valida: got %b want 0", saida_valida); end
    tests++; if (saida !== 128'h0) begin fails++; $display("FAIL mid_saida: got %h want 0", saida); end
    tests++; if (entrada_pronta !== 1'b1) begin fails++; $display("FAIL mid_pronta: got %b want 1", entrada_pronta); end
    repeat (15) begin
      tick();
      if (saida_valida !== 1'b0) stale = 1'b1;
    end
    tests++; if (stale) begin fails++; $display("FAIL mid_stale: valida got 1 want 0 after reset"); end
    apply(CT_B, KEY_B);
    entrada_valida = 1'b1;
    tick();
    entrada_valida = 1'b0;
    wait_valid(ok);
    tests++; if (!ok || saida !== PT_B) begin fails++; $display("FAIL mid_fresh_b: got %h want %h", saida, PT_B); end
    tick();
  endtask

  task automatic test_random();
    logic [127:0] key, pt, obs;
    logic [1407:0] ks;
    bit acc, got;
    for (int n = 0; n < 1000; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      ks  = key_expand(key);
      bloco_cifrado  = encrypt(pt, ks);
      chaveInicial   = key;
      chaveExpandida = ks[1279:0];
      saida_pronta   = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      entrada_valida = 1'b1;
      acc = 1'b0;
      for (int g = 0; g < 30 && !acc; g++) begin
        acc = entrada_pronta;
        tick();
      end
      entrada_valida = 1'b0;
      got = 1'b0;
      obs = '0;
      for (int g = 0; g < 60 && !got; g++) begin
        saida_pronta = ($urandom_range(0, 3) != 0);
        if (saida_valida && saida_pronta) begin
          obs = saida;
          got = 1'b1;
        end
        tick();
      end
      tests++;
      if (!acc || !got || obs !== pt) begin
        fails++;
        $display("FAIL rand_%0d: got %h want %h (accepted=%b output=%b)", n, obs, pt, acc, got);
      end
    end
    saida_pronta = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; entrada_valida = 1'b0; saida_pronta = 1'b0;
    bloco_cifrado = '0; chaveInicial = '0; chaveExpandida = '0;
    build_sbox();
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decifra_aes_iterativa.md
# decifra_aes_iterativa

Iterative AES-128 inverse cipher (decryption) that processes one round per clock. It is the receive-side counterpart of the encryption datapath. It accepts a 128-bit ciphertext block plus the 11 round keys through a valid/ready handshake, runs the initial AddRoundKey and then ten inverse rounds, and presents the plaintext through a second valid/ready handshake. It sits between the key-expansion logic and the consumer of recovered plaintext.

## Interface
- No parameters; fixed to AES-128 (Nr = 10).
- clock  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- entrada_valida  input  1  ciphertext, chaveInicial and chaveExpandida are valid.
- entrada_pronta  output  1  block can accept a new input.
- bloco_cifrado  input  128  ciphertext; bits [127:120] are byte 0, column-major (byte 4c+r = state row r, column c).
- chaveInicial  input  128  round key 0 (the cipher key).
- chaveExpandida  input  1280  round keys 1..10; round key r at bits [128*(11-r)-1 : 128*(10-r)], so key 1 is [1279:1152] and key 10 is [127:0].
- saida_valida  output  1  plaintext on `saida` is valid.
- saida_pronta  input  1  consumer accepts `saida`.
- saida  output  128  plaintext, same byte order as `bloco_cifrado`.

## Operation
- FSM states:
  - OCIOSO: `entrada_pronta`=1.
  - RODADA: computing.
  - CONCLUIDO: `saida_valida`=1.
- 4-bit round counter `r`. State register `estado` is 128 bits. The key register holds all 11 round keys (1408 bits).
- **Accept.** An input is accepted on an edge where `entrada_valida` & `entrada_pronta` are both high. On that edge:
  - `estado` <= `bloco_cifrado` ^ rk10.
  - All 11 keys are captured; inputs may change afterwards.
  - `r` <= 9.
  - The FSM goes to RODADA.
- **Round step.** Each RODADA edge with `r` ≥ 1:
  - `estado` <= InvMixColumns(InvSubBytes(InvShiftRows(`estado`)) ^ rk[r]).
  - `r` <= `r`-1.
- **Final round.** RODADA edge with `r` = 0:
  - `estado` <= InvSubBytes(InvShiftRows(`estado`)) ^ rk0.
  - The FSM goes to CONCLUIDO.
- **InvShiftRows:** row r is rotated right by r byte positions; row 0 is unchanged.
- **InvSubBytes:** FIPS-197 inverse S-box applied to all 16 bytes. It is purely combinational (case ROM or function).
- **InvMixColumns:** each column is multiplied by the matrix [0e 0b 0d 09] rotated per row, in GF(2^8) with reduction polynomial 0x11B. Multiplication is built from xtime chains; no multipliers.
- **Output.**
  - `saida` = `estado` while in CONCLUIDO, and is held stable until `saida_valida` & `saida_pronta`.
  - On the handshake edge the FSM returns to OCIOSO. `saida` keeps its last value; consumers qualify it with `saida_valida`.
- **Flow control.**
  - `entrada_pronta` is 0 in RODADA and CONCLUIDO. There is no overlap of a new input with a pending output.
  - `entrada_valida` asserted outside OCIOSO is ignored; the input is not consumed.
  - `saida_pronta` is ignored outside CONCLUIDO.
- **Reset** (any state, including mid-round):
  - FSM goes to OCIOSO, `r`=0, `estado`=0, key register=0.
  - `saida_valida`=0, `entrada_pronta`=1 in the cycle after reset deasserts.
  - An in-flight block is discarded and no output is produced for it.
  - If reset and `entrada_valida` are high on the same edge, reset wins and the input is not accepted.

## Timing
- Reset values: `entrada_pronta`=1 (OCIOSO), `saida_valida`=0, `saida`=128'h0.
- Acceptance edge T: `saida_valida` rises after edge T+10 and is first visible in the cycle following T+10. That is 10 round edges after the load edge, 11 edges total.
- Minimum period between acceptances is 12 cycles: 11 compute edges plus 1 output-handshake edge, assuming `saida_pronta` is already high.
- `entrada_pronta` rises in the cycle after the output handshake edge.
- Output backpressure of N extra cycles delays the next `entrada_pronta` by exactly N.
- Outputs `entrada_pronta` and `saida_valida` are decoded directly from the FSM state register, with no combinational path from inputs. `saida` is `estado` directly.

## Test plan
- **FIPS-197 C.1.**
  - Stimulus: key 000102030405060708090a0b0c0d0e0f (rk10 = 13111d7fe3944a17f307a78b4d2b30c5), ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, `saida_pronta`=1.
  - Required: `saida`=00112233445566778899aabbccddeeff, `saida_valida` high exactly 11 edges after acceptance, for exactly 1 cycle.
- **FIPS-197 B.**
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32.
  - Required: `saida`=3243f6a8885a308d313198a2e0370734.
- **Backpressure and key capture.**
  - Stimulus: C.1 vector with `saida_pronta`=0 for 5 cycles after `saida_valida` rises; bench changes `bloco_cifrado`/keys right after acceptance.
  - Required: `saida` is stable and correct for all 6 cycles, `entrada_pronta` stays 0 throughout, and the changed inputs have no effect.
- **Back-to-back.**
  - Stimulus: `entrada_valida` held high with B and C.1 vectors queued.
  - Required: acceptances are 12 cycles apart, both outputs are correct and in order, and the second input is not consumed while `entrada_pronta`=0.
- **Reset mid-operation.**
  - Stimulus: assert reset 5 cycles after accepting C.1.
  - Required: next cycle `saida_valida`=0, `saida`=0, `entrada_pronta`=1; no stale output appears; a fresh B vector then decrypts correctly.
- **Random regression.**
  - Stimulus: 1000 random keys and plaintexts, encrypted and key-expanded by the software model, with random `entrada_valida`/`saida_pronta` stalls.
  - Required: every `saida` equals the original plaintext.
